dcache_direct: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache. Responder side of the core's data-memory request interface (addr/data_in/write_enable/read_enable → data_out/ready/miss).
- Replaces the always-hit memory stub.
- Core side: one word per request. Memory side: whole 4-word (128-bit) lines over a req/ready + rvalid handshake to the DRAM controller.

---
 rtl/dcache_direct.sv | 217 +++++++++++++++++++++
 tb/tb_dcache_direct.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Core side: one 32-bit word per request. Memory side: whole 128-bit lines
// over a req/ready handshake, with refill data returned on an rvalid pulse.
// Optional build macro: DCACHE_STATS_EN adds 32-bit hit/miss counters;
// without it hit_count/miss_count are tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no request in flight, ready for a new one
// S_LOOKUP  | array read data available, tag compare / hit completion
// S_WB      | writing the dirty victim line back to memory
// S_REFILL  | requesting the missing line from memory
// S_WAIT    | refill accepted, waiting for mem_rvalid
// S_RESPOND | miss resolved, request completes this cycle
module dcache_direct #(
  parameter int INDEX_W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  addr,
  input  logic [31:0]  data_in,
  input  logic         write_enable,
  input  logic         read_enable,
  output logic [31:0]  data_out,
  output logic         ready,
  output logic         miss,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [127:0] mem_rdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int TAG_W = 28 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_REFILL,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [31:2]        req_addr_q;
  logic [31:0]        req_wdata_q;
  logic               req_we_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [31:0]        data_out_q;

  logic [TAG_W-1:0]   tag_ram  [LINES];
  logic [127:0]       data_ram [LINES];
  logic [TAG_W-1:0]   rd_tag_q;
  logic [127:0]       rd_line_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_off;
  logic [INDEX_W-1:0] cap_idx;
  logic               capture;
  logic               hit;
  logic               lookup_hit;
  logic               refill_done;
  logic               wr_en;
  logic [127:0]       wr_line;
  logic [31:0]        rd_word;
  logic [31:0]        wr_word;
  logic               unused_addr_lsb;

  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [1:0]   off,
                                              input logic [31:0]  word);
    logic [127:0] r;
    r = line;
    r[{off, 5'b0} +: 32] = word;
    return r;
  endfunction

  assign unused_addr_lsb = ^addr[1:0];

  assign req_tag = req_addr_q[31:4+INDEX_W];
  assign req_idx = req_addr_q[4+INDEX_W-1:4];
  assign req_off = req_addr_q[3:2];
  assign cap_idx = addr[4+INDEX_W-1:4];

  assign hit         = valid_q[req_idx] && (rd_tag_q == req_tag);
  assign lookup_hit  = (state_q == S_LOOKUP) && hit;
  assign refill_done = (state_q == S_WAIT) && mem_rvalid;

  assign miss = ((state_q == S_LOOKUP) && !hit) ||
                (state_q == S_WB) || (state_q == S_REFILL) || (state_q == S_WAIT);
  assign ready   = ~miss;
  assign capture = ready && (read_enable || write_enable);

  assign rd_word = rd_line_q[{req_off, 5'b0} +: 32];
  assign wr_word = wr_line[{req_off, 5'b0} +: 32];

  // Single array write port: store hits patch one word of the line read at
  // capture; refills write the returned line with any pending store merged.
  always_comb begin
    wr_en   = 1'b0;
    wr_line = rd_line_q;
    if (lookup_hit && req_we_q) begin
      wr_en   = rstn;
      wr_line = merge_word(rd_line_q, req_off, req_wdata_q);
    end else if (refill_done) begin
      wr_en   = rstn;
      wr_line = req_we_q ? merge_word(mem_rdata, req_off, req_wdata_q) : mem_rdata;
    end
  end

  // Tag/data RAMs with registered read; a same-index write in the capture
  // cycle is bypassed into the read registers so the next lookup sees it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_ram[req_idx]  <= req_tag;
      data_ram[req_idx] <= wr_line;
    end
    if (capture) begin
      if (wr_en && (req_idx == cap_idx)) begin
        rd_tag_q  <= req_tag;
        rd_line_q <= wr_line;
      end else begin
        rd_tag_q  <= tag_ram[cap_idx];
        rd_line_q <= data_ram[cap_idx];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (capture) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)                                  state_d = capture ? S_LOOKUP : S_IDLE;
        else if (valid_q[req_idx] && dirty_q[req_idx]) state_d = S_WB;
        else                                      state_d = S_REFILL;
      end
      S_WB:      if (mem_ready)  state_d = S_REFILL;
      S_REFILL:  if (mem_ready)  state_d = S_WAIT;
      S_WAIT:    if (mem_rvalid) state_d = S_RESPOND;
      S_RESPOND: state_d = capture ? S_LOOKUP : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register, request latch, valid/dirty flops and load-data hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      data_out_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        req_addr_q  <= addr[31:2];
        req_wdata_q <= data_in;
        req_we_q    <= write_enable;
      end
      if (lookup_hit) begin
        if (req_we_q) dirty_q[req_idx] <= 1'b1;
        else          data_out_q       <= rd_word;
      end
      if (refill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= req_we_q;
        data_out_q       <= wr_word;
      end
    end
  end

  assign data_out  = (lookup_hit && !req_we_q) ? rd_word : data_out_q;
  assign mem_req   = (state_q == S_WB) || (state_q == S_REFILL);
  assign mem_we    = (state_q == S_WB);
  assign mem_wdata = (state_q == S_WB) ? rd_line_q : '0;
  assign mem_addr  = (state_q == S_WB)     ? {rd_tag_q, req_idx, 4'b0} :
                     (state_q == S_REFILL) ? {req_tag,  req_idx, 4'b0} : 32'd0;

`ifdef DCACHE_STATS_EN
  logic        lookup_miss;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign lookup_miss = (state_q == S_LOOKUP) && !hit;

  // Count every lookup outcome; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: core-side scoreboard of expected
// completions, an architectural memory model, and a memory responder that
// checks every line transfer against the expected transaction sequence.
module tb_dcache_direct;

  typedef struct {
    logic        hit;
    logic        chk_data;
    logic [31:0] exp;
    logic [31:0] a;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  addr;
  logic [31:0]  data_in;
  logic         write_enable;
  logic         read_enable;
  logic [31:0]  data_out;
  logic         ready;
  logic         miss;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t         exp_q[$];
  logic [32:0]  txn_q[$];
  logic [31:0]  gold      [logic [29:0]];
  logic [127:0] mem_model [logic [31:0]];
  bit           mvalid [256];
  bit           mdirty [256];
  logic [31:0]  mline  [256];
  int           m_hits, m_misses;
  int           ready_delay, rlat;

  dcache_direct #(.INDEX_W(8)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .data_in(data_in),
    .write_enable(write_enable), .read_enable(read_enable),
    .data_out(data_out), .ready(ready), .miss(miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] la);
    if (la == 32'h100) return {32'h44, 32'h33, 32'h22, 32'h11};
    return {la + 32'd12, la + 32'd8, la + 32'd4, la} ^ {4{32'h5A5A_0000}};
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    if (mem_model.exists(la)) return mem_model[la];
    return init_line(la);
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [127:0] l;
    if (gold.exists(a[31:2])) return gold[a[31:2]];
    l = mem_line({a[31:4], 4'b0}) >> (32 * a[3:2]);
    return l[31:0];
  endfunction

  function automatic logic [127:0] gold_line(input logic [31:0] la);
    return {gold_word(la + 32'd12), gold_word(la + 32'd8), gold_word(la + 32'd4), gold_word(la)};
  endfunction

  task automatic check_reset_state();
    chk("rst_miss", miss, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    read_enable = 1'b0;
    write_enable = 1'b0;
    exp_q.delete();
    txn_q.delete();
    gold.delete();
    for (int i = 0; i < 256; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mline[i]  = '0;
    end
    m_hits = 0;
    m_misses = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check_reset_state();
  endtask

  // Issue one request at a negedge once ready is seen; the model predicts
  // hit/miss, memory transactions and the completion value.
  task automatic issue(input bit is_store, input bit both, input logic [31:0] a,
                       input logic [31:0] d);
    int g = 0;
    logic [7:0]  idx;
    logic [31:0] la;
    exp_t it;
    while (ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", ready, 1'b1);
    idx = a[11:4];
    la  = {a[31:4], 4'b0};
    it.hit = mvalid[idx] && (mline[idx] == la);
    if (it.hit) begin
      m_hits++;
      if (is_store) mdirty[idx] = 1'b1;
    end else begin
      m_misses++;
      if (mvalid[idx] && mdirty[idx]) txn_q.push_back({1'b1, mline[idx]});
      txn_q.push_back({1'b0, la});
      mvalid[idx] = 1'b1;
      mline[idx]  = la;
      mdirty[idx] = is_store;
    end
    if (is_store) gold[a[31:2]] = d;
    it.chk_data = !is_store || !it.hit;
    it.exp      = is_store ? d : gold_word(a);
    it.a        = a;
    exp_q.push_back(it);
    write_enable = is_store;
    read_enable  = !is_store || both;
    addr    = a;
    data_in = d;
    @(negedge clk);
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || ready !== 1'b1) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Completion monitor: pops one expectation whenever miss is low with a
  // request outstanding.
  initial begin
    int waited = 0;
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        waited = 0;
        continue;
      end
      if (exp_q.size() > 0) begin
        if (miss === 1'b0) begin
          it = exp_q.pop_front();
          chk($sformatf("hit@%0h", it.a), (waited == 0), it.hit);
          if (it.chk_data) chk($sformatf("data@%0h", it.a), data_out, it.exp);
          waited = 0;
        end else begin
          waited++;
          if (waited > 400) begin
            chk("resp_timeout", waited, 0);
            void'(exp_q.pop_front());
            waited = 0;
          end
        end
      end
    end
  end

  // Memory responder: ready after ready_delay stall cycles, refill data
  // rlat cycles after acceptance; checks hold stability and transfer content.
  initial begin
    int           stall = 0;
    int           cur_delay = 0;
    int           rd_cnt = 0;
    bit           rd_pending = 1'b0;
    logic [127:0] rd_line = '0;
    logic [32:0]  s_addr = '0;
    logic [127:0] s_wdata = '0;
    logic [32:0]  t;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_line;
          rd_pending = 1'b0;
        end else rd_cnt--;
      end
      if (!rstn) stall = 0;
      else if (mem_req === 1'b1) begin
        if (stall == 0) begin
          cur_delay = ready_delay;
          s_addr  = {mem_we, mem_addr};
          s_wdata = mem_wdata;
        end else begin
          chk("mem_hold_addr", {mem_we, mem_addr}, s_addr);
          chk("mem_hold_wdata", mem_wdata, s_wdata);
          chk("mem_hold_miss", miss, 1'b1);
        end
        if (stall >= cur_delay) begin
          mem_ready = 1'b1;
          stall = 0;
          t = (txn_q.size() > 0) ? txn_q.pop_front() : 33'h1_FFFF_FFFF;
          chk("mem_txn", {mem_we, mem_addr}, t);
          if (mem_we) begin
            chk($sformatf("wb_data@%0h", mem_addr), mem_wdata, gold_line(mem_addr));
            mem_model[mem_addr] = gold_line(mem_addr);
          end else begin
            rd_pending = 1'b1;
            rd_cnt     = rlat - 1;
            rd_line    = mem_line(mem_addr);
          end
        end else stall++;
      end
    end
  end

  initial begin
    int g;
    int tags[4];
    logic [31:0] a;
    tags[0] = 32'h0000; tags[1] = 32'h1000; tags[2] = 32'h2000; tags[3] = 32'h4000;
    rstn = 1'b0;
    read_enable = 1'b0;
    write_enable = 1'b0;
    addr = '0;
    data_in = '0;
    ready_delay = 0;
    rlat = 5;
    do_reset();

    issue(0, 0, 32'h100, 0);
    issue(0, 0, 32'h104, 0);
    issue(1, 0, 32'h108, 32'hDEAD_BEEF);
    issue(0, 0, 32'h108, 0);
    ready_delay = 3;
    issue(1, 0, 32'h100, 32'h0000_CAFE);
    issue(0, 0, 32'h1100, 0);
    drain();

    ready_delay = 0;
    rlat = 2;
    issue(1, 1, 32'h2004, 32'h5);
    issue(0, 0, 32'h2000, 0);
    issue(0, 0, 32'h2004, 0);
    issue(0, 0, 32'h6000, 0);
    drain();

    for (int i = 0; i < 40; i++) begin
      a = tags[$urandom_range(0, 3)] | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      ready_delay = $urandom_range(0, 2);
      rlat = $urandom_range(1, 4);
      issue($urandom_range(0, 1) == 1, 0, a, $urandom);
    end
    drain();

    ready_delay = 0;
    rlat = 5;
    issue(0, 0, 32'h3000, 0);
    g = 0;
    while (mem_req !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    chk("abort_req_seen", mem_req, 1'b1);
    g = 0;
    while (mem_req !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    chk("abort_in_wait", {miss, mem_req}, 2'b10);
    do_reset();
    repeat (3) @(negedge clk);
    chk("post_abort_idle", {miss, ready}, 2'b01);

    issue(0, 0, 32'h100, 0);
    issue(0, 0, 32'h104, 0);
    issue(0, 0, 32'h108, 0);
    issue(0, 0, 32'h10C, 0);
    issue(0, 0, 32'h3000, 0);
    drain();
    repeat (2) @(negedge clk);

`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`else
    chk("hit_count", hit_count, 32'd0);
    chk("miss_count", miss_count, 32'd0);
`endif
    chk("txn_q_empty", txn_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
